// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 datapath blocks: ALU op encodings, the
// multiply sequencer state set and the machine word width.
// Pure declarations; no logic, no latency, no flow control.
package slc3_pkg;

    localparam int WORD_W = 16;

    // Op-select encoding understood by the datapath ALU.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PASSA = 2'b11
    } alu_op_t;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DBL  = 2'b01,
        ADD  = 2'b10,
        DONE = 2'b11
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential 16x16->16 multiplier that borrows the datapath ALU (ADD only), MSB-first shift-and-add.
// Latency: done in cycle 33 after the accepting edge; with MUL_SKIP_ZERO_EN, cycle 17+popcount(multiplier).
// Backpressure: start is taken only while ready=1; starts during busy or DONE are dropped.
//
// Build option: define MUL_SKIP_ZERO_EN to skip the accumulate step for zero multiplier bits.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   start               operation request, honoured only when ready=1
//   mcand_in, mplier_in multiplicand / multiplier, captured on an accepted start
//   ready               high in IDLE
//   busy                high in DBL/ADD; datapath routes alu_a/alu_b/alu_k into the ALU
//   alu_a, alu_b, alu_k ALU operands and op select (always ADD)
//   alu_out             combinational ALU result for the current alu_a/alu_b/alu_k
//   done                one-cycle pulse, product valid
//   product             result register, held until the next accepted start completes
module alu_mul_seq
    import slc3_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [WORD_W-1:0] mcand_in,
    input  logic [WORD_W-1:0] mplier_in,
    output logic              ready,
    output logic              busy,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [1:0]        alu_k,
    input  logic [WORD_W-1:0] alu_out,
    output logic              done,
    output logic [WORD_W-1:0] product
);

    mul_state_t        state_q, state_d;
    logic [WORD_W-1:0] m_q, m_d;        // multiplicand
    logic [WORD_W-1:0] q_q, q_d;        // multiplier
    logic [WORD_W-1:0] p_q, p_d;        // running partial product
    logic [3:0]        cnt_q, cnt_d;    // multiplier bit being scanned, 15 down to 0
    logic [WORD_W-1:0] prod_q, prod_d;  // published result

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        alu_a   = '0;
        alu_b   = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = mcand_in;
                    q_d     = mplier_in;
                    p_d     = '0;
                    cnt_d   = 4'd15;
                    state_d = DBL;
                end
            end

            DBL: begin
                // P+P is a left shift by one; the ALU drops the carry out of bit 15.
                alu_a = p_q;
                alu_b = p_q;
                p_d   = alu_out;
`ifdef MUL_SKIP_ZERO_EN
                if (q_q[cnt_q]) begin
                    state_d = ADD;
                end else if (cnt_q == 4'd0) begin
                    // Last bit was zero: the doubled value is already the result.
                    prod_d  = alu_out;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = DBL;
                end
`else
                state_d = ADD;
`endif
            end

            ADD: begin
                alu_a = p_q;
                alu_b = q_q[cnt_q] ? m_q : '0;
                p_d   = alu_out;
                if (cnt_q == 4'd0) begin
                    prod_d  = alu_out;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = DBL;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            cnt_q   <= 4'd15;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == DBL) || (state_q == ADD);
    assign done    = (state_q == DONE);
    assign alu_k   = ALU_ADD;
    assign product = prod_q;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that borrows the shared 16-bit ALU to compute `mcand_in * mplier_in`, keeping the low 16 bits. It uses MSB-first shift-and-add built only from ALU ADD operations (`P+P` doubles, `P+M` accumulates). It sits beside the register-file/ALU datapath and drives the ALU operand and op-select lines through the datapath's ALU input mux while `busy` is high. The control FSM hands it operands with a start pulse and collects the product on `done`.

## Interface
- No parameters; width fixed at 16.
- `Clk` in 1: single clock, all state on rising edge.
- `Reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only when `ready`=1.
- `mcand_in` in 16: multiplicand M, latched on accepted start.
- `mplier_in` in 16: multiplier Q, latched on accepted start; bits scanned 15→0.
- `ready` out 1: 1 in IDLE only.
- `busy` out 1: 1 in DBL/ADD; datapath selects this block's ALU operands when high.
- `alu_a`, `alu_b` out 16: ALU operands.
- `alu_k` out 2: ALU op select; always 2'b00 (ADD).
- `alu_out` in 16: ALU result, combinational from `alu_a`/`alu_b`/`alu_k`.
- `done` out 1: single-cycle pulse, product valid.
- `product` out 16: result register, held until the next accepted start.

## Operation
- States: IDLE, DBL, ADD, DONE.
- IDLE: if `start`, latch M←`mcand_in`, Q←`mplier_in`, P←0, cnt←15; go to DBL. Otherwise stay.
- DBL: `alu_a`=P, `alu_b`=P. At the edge, P←`alu_out`, go to ADD.
- ADD: `alu_a`=P, `alu_b`=Q[cnt] ? M : 0. At the edge, P←`alu_out`. If cnt==0, go to DONE and `product`←`alu_out`. Otherwise cnt←cnt−1 and go to DBL.
- DONE: `done`=1; go to IDLE unconditionally. A start seen in DONE is ignored.
- Outside DBL/ADD: `alu_a`=`alu_b`=0 and `alu_k`=00. These values are don't-care to the datapath but must be defined.
- Arithmetic is modulo 2^16. Carries out of bit 15 are discarded by the ALU.
- The low 16 bits are correct for both signed and unsigned operands; no sign handling is needed.
- `start` while `busy`=1 or in DONE is ignored; operands and P are unaffected.
- `Reset` at any time, including mid-operation, forces IDLE, P=0, `product`=0, `done`=0, cnt=15. The in-flight result is discarded.

## Timing
- Reset values: `ready`=1, `busy`=0, `done`=0, `product`=0, `alu_a`=`alu_b`=0, `alu_k`=00.
- The start-accept edge is cycle 0.
- DBL/ADD occupy cycles 1–32 in base configuration, alternating DBL, ADD.
- `done`=1 and the new `product` are visible in cycle 33. `ready`=1 again in cycle 34.
- The earliest next accepted start is at the edge ending cycle 34.
- `product` updates only at the final ADD edge (or on reset). It is stable during `busy`.
- ALU path is combinational within one cycle. No pipeline registers exist between `alu_a`/`alu_b` and `alu_out`.

## Configuration
- `MUL_SKIP_ZERO_EN` undefined: ADD is always executed (adding 0 when Q[cnt]=0). Latency is fixed: `done` in cycle 33.
- `MUL_SKIP_ZERO_EN` defined: ADD is skipped when Q[cnt]=0.
  - DBL then goes directly to DBL with cnt−1.
  - When cnt==0, DBL goes to DONE and `product`←`alu_out`.
  - Latency is `done` in cycle 17+popcount(Q).
- The result is identical in both configurations.

## Structure
- Shared package `slc3_pkg`:
  - `alu_op_t` enum: `ALU_ADD`=00, `ALU_AND`=01, `ALU_NOT`=10, `ALU_PASSA`=11.
  - `mul_state_t` enum: IDLE, DBL, ADD, DONE.
  - `WORD_W`=16.
- No sub-module. The ALU stays instantiated in the datapath. This block holds only the M, Q, P, cnt and `product` registers plus the FSM.

## Test plan
- Basic multiply: M=3, Q=5, start pulse → `done` in cycle 33, `product`=0x000F, `busy` high cycles 1–32, `alu_k`=00 throughout.
- Wrap-around: M=0xFFFF, Q=0xFFFF → `product`=0x0001. Also M=0x0100, Q=0x0100 → `product`=0x0000.
- Zero multiplier: M=0x1234, Q=0 → `product`=0x0000, `done` in cycle 33 (base).
- Busy/done starts: start held high with new operands 7×9 during cycles 1–33 → ignored; first product is still 0x000F; 7×9 is accepted only when `ready`=1 → 0x003F.
- Reset mid-operation: reset asserted in cycle 10 → next cycle `ready`=1, `product`=0, `done`=0; a following 2×2 gives 0x0004.
- `MUL_SKIP_ZERO_EN` latency: 3×5 → `done` in cycle 19, `product`=0x000F. Q=0x8000, M=1 → `done` in cycle 18, `product`=0x8000.
